// File: rtl/pll_dyn_phase_ctrl.sv
// Retune sequencer for the dynamic phase/duty/fine-delay controls of NUM_CH rPLLs.
// Phase is walked one LSB per step along the shortest path, with a settle wait and lock supervision.
module pll_dyn_phase_ctrl #(
   parameter int NUM_CH        = 2,
   parameter int CH_W          = 3,
   parameter int SETTLE_CYCLES = 16,
   parameter int LOCK_FILTER   = 8
) (
   input  logic                clkin,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [CH_W-1:0]     req_ch,
   input  logic [3:0]          req_psda,
   input  logic [3:0]          req_duty,
   input  logic [3:0]          req_fdly,
   input  logic [NUM_CH-1:0]   pll_lock,
   output logic [4*NUM_CH-1:0] psda_o,
   output logic [4*NUM_CH-1:0] dutyda_o,
   output logic [4*NUM_CH-1:0] fdly_o,
   output logic [NUM_CH-1:0]   locked_o,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int LCNT_W = $clog2(LOCK_FILTER + 1);
   localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_STEP, S_SETTLE, S_DUTY, S_DONE, S_ERR
   } state_t;

   state_t state, state_nxt;

   logic [NUM_CH-1:0] lock_meta, lock_sync;
   logic [LCNT_W-1:0] lock_cnt [NUM_CH];

   logic [3:0]        psda_q [NUM_CH];
   logic [3:0]        duty_q [NUM_CH];
   logic [3:0]        fdly_q [NUM_CH];

   logic [CH_W-1:0]   ch_q;
   logic [3:0]        tgt_q, rduty_q, rfdly_q;
   logic              dir_up_q;
   logic [SCNT_W-1:0] settle_cnt;

   logic              ch_ok, cur_locked, cur_sync;
   logic [3:0]        cur_psda, diff;

   // Lock path: two-flop synchroniser, then a saturating run-length counter per channel.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= '0;
         lock_sync <= '0;
         for (int i = 0; i < NUM_CH; i++) lock_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments here are what make lock_meta -> lock_sync two real flops.
         lock_meta <= pll_lock;
         lock_sync <= lock_meta;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!lock_sync[i])
               lock_cnt[i] <= '0;
            else if (lock_cnt[i] != LCNT_W'(LOCK_FILTER))
               lock_cnt[i] <= lock_cnt[i] + LCNT_W'(1);
         end
      end
   end

   // Gating with lock_sync makes locked_o fall in the very cycle the synchronised bit drops.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         locked_o[i] = lock_sync[i] && (lock_cnt[i] == LCNT_W'(LOCK_FILTER));
   end

   // Selected-channel view; an out-of-range channel simply leaves ch_ok low.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      ch_ok      = 1'b0;
      cur_locked = 1'b0;
      cur_sync   = 1'b0;
      cur_psda   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_q == CH_W'(i)) begin
            ch_ok      = 1'b1;
            cur_locked = locked_o[i];
            cur_sync   = lock_sync[i];
            cur_psda   = psda_q[i];
         end
      end
   end

   assign diff = tgt_q - cur_psda;

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (req_valid) state_nxt = S_CHECK;
         S_CHECK: begin
            if (!ch_ok || !cur_locked) state_nxt = S_ERR;
            else if (diff == 4'd0)     state_nxt = S_DUTY;
            else                       state_nxt = S_STEP;
         end
         S_STEP:   state_nxt = S_SETTLE;
         S_SETTLE: begin
            if (!cur_sync)                        state_nxt = S_ERR;
            else if (settle_cnt == SCNT_W'(1))    state_nxt = (cur_psda == tgt_q) ? S_DUTY : S_STEP;
         end
         S_DUTY:   state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         S_ERR:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath: request capture, per-channel code registers, settle timer and the pulse outputs.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         // NOTE: the code arrays are a handful of flops driving the PLLs, so they take a real reset value.
         for (int i = 0; i < NUM_CH; i++) begin
            psda_q[i] <= 4'b0000;
            duty_q[i] <= 4'b1000;
            fdly_q[i] <= 4'b0000;
         end
         ch_q       <= '0;
         tgt_q      <= '0;
         rduty_q    <= '0;
         rfdly_q    <= '0;
         dir_up_q   <= 1'b0;
         settle_cnt <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= (state == S_DONE);
         err  <= (state == S_ERR);
         case (state)
            S_IDLE: if (req_valid) begin
               ch_q    <= req_ch;
               tgt_q   <= req_psda;
               rduty_q <= req_duty;
               rfdly_q <= req_fdly;
            end
            S_CHECK:  dir_up_q <= (diff <= 4'd8);
            S_STEP: begin
               for (int i = 0; i < NUM_CH; i++)
                  if (ch_q == CH_W'(i))
                     psda_q[i] <= dir_up_q ? psda_q[i] + 4'd1 : psda_q[i] - 4'd1;
               settle_cnt <= SCNT_W'(SETTLE_CYCLES);
            end
            S_SETTLE: settle_cnt <= settle_cnt - SCNT_W'(1);
            S_DUTY: begin
               for (int i = 0; i < NUM_CH; i++)
                  if (ch_q == CH_W'(i)) begin
                     duty_q[i] <= rduty_q;
                     fdly_q[i] <= rfdly_q;
                  end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         psda_o[4*i +: 4]   = psda_q[i];
         dutyda_o[4*i +: 4] = duty_q[i];
         fdly_o[4*i +: 4]   = fdly_q[i];
      end
   end

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_pll_dyn_phase_ctrl.sv
// Scoreboard bench for pll_dyn_phase_ctrl: directed requests push expected done/err responses,
// a monitor pops and compares them whenever a pulse appears.
module tb_pll_dyn_phase_ctrl;

   localparam int NUM_CH = 2;
   localparam int CH_W   = 3;

   logic                clkin = 1'b0;
   logic                resetn;
   logic                req_valid;
   logic                req_ready;
   logic [CH_W-1:0]     req_ch;
   logic [3:0]          req_psda, req_duty, req_fdly;
   logic [NUM_CH-1:0]   pll_lock;
   logic [4*NUM_CH-1:0] psda_o, dutyda_o, fdly_o;
   logic [NUM_CH-1:0]   locked_o;
   logic                busy, done, err;

   pll_dyn_phase_ctrl #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYCLES(4), .LOCK_FILTER(8)
   ) dut (
      .clkin(clkin), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ch(req_ch), .req_psda(req_psda), .req_duty(req_duty), .req_fdly(req_fdly),
      .pll_lock(pll_lock),
      .psda_o(psda_o), .dutyda_o(dutyda_o), .fdly_o(fdly_o),
      .locked_o(locked_o), .busy(busy), .done(done), .err(err)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      bit         is_err;
      int         due;
      logic [7:0] psda;
      logic [7:0] duty;
      logic [7:0] fdly;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] seen[$];
   logic [3:0] prev_psda0;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clkin) cyc <= cyc + 1;

   // Monitor: every done/err pulse must match the oldest outstanding expectation.
   always @(negedge clkin) begin : monitor
      exp_t e;
      if (resetn === 1'b1 && (done || err)) begin
         if (sb.size() == 0) begin
            check("no_pulse", {30'd0, done, err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("kind_err",  {31'd0, err},  {31'd0, e.is_err});
            check("kind_done", {31'd0, done}, {31'd0, !e.is_err});
            check("latency",   cyc, e.due);
            check("psda",      psda_o, e.psda);
            check("dutyda",    dutyda_o, e.duty);
            check("fdly",      fdly_o, e.fdly);
            check("busy_low",  {31'd0, busy}, 32'd0);
         end
      end
   end

   // Records every change of ch0's phase code so walk direction and wrap can be checked.
   always @(negedge clkin) begin
      if (resetn !== 1'b1) prev_psda0 = 4'd0;
      else if (psda_o[3:0] != prev_psda0) begin
         seen.push_back(psda_o[3:0]);
         prev_psda0 = psda_o[3:0];
      end
   end

   task automatic send(input logic [CH_W-1:0] ch, input logic [3:0] p, d, f,
                       input bit push, input bit e_err, input int lat,
                       input logic [7:0] ep, ed, ef);
      exp_t e;
      int   n = 0;
      @(negedge clkin);
      req_ch = ch; req_psda = p; req_duty = d; req_fdly = f; req_valid = 1'b1;
      while (!req_ready && n < 100) begin
         @(negedge clkin);
         n++;
      end
      check("ready_wait", {31'd0, req_ready}, 32'd1);
      @(posedge clkin);
      @(negedge clkin);
      req_valid = 1'b0;
      req_ch = ~ch; req_psda = ~p; req_duty = ~d; req_fdly = ~f;
      if (push) begin
         e.is_err = e_err; e.due = cyc + lat; e.psda = ep; e.duty = ed; e.fdly = ef;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clkin);
         n++;
      end
      check("sb_drained", sb.size(), 32'd0);
      @(negedge clkin);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int         offs[8] = '{1, 2, 6, 7, 11, 12, 16, 17};
      logic [3:0] op[8]   = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h3};
      logic [3:0] od[8]   = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h6};
      logic [3:0] of[8]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
      logic [3:0] wrap_a[3] = '{4'h0, 4'hF, 4'hE};
      logic [3:0] wrap_b[8] = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      int k;

      resetn = 1'b0; req_valid = 1'b0; req_ch = '0;
      req_psda = '0; req_duty = '0; req_fdly = '0; pll_lock = 2'b01;
      repeat (3) @(negedge clkin);
      check("rst_psda",  psda_o, 8'h00);
      check("rst_duty",  dutyda_o, 8'h88);
      check("rst_fdly",  fdly_o, 8'h00);
      check("rst_lock",  locked_o, 2'b00);
      check("rst_flags", {busy, done, err}, 3'b000);
      check("rst_ready", req_ready, 1'b1);
      resetn = 1'b1;
      repeat (12) @(negedge clkin);
      check("ch0_locked", locked_o, 2'b01);

      // Rejects: unlocked channel, then out-of-range channel.
      send(3'd1, 4'h5, 4'h3, 4'h3, 1, 1, 2, 8'h00, 8'h88, 8'h00);
      wait_idle();
      send(3'd2, 4'h5, 4'h3, 4'h3, 1, 1, 2, 8'h00, 8'h88, 8'h00);
      wait_idle();

      // Three up-steps with per-step timing of the phase and duty/fdly update.
      send(3'd0, 4'h3, 4'h6, 4'h2, 1, 0, 18, 8'h03, 8'h86, 8'h02);
      k = 0;
      for (int t = 1; t <= 17; t++) begin
         @(negedge clkin);
         if (k < 8 && t == offs[k]) begin
            check("step_psda", psda_o[3:0], op[k]);
            check("step_duty", dutyda_o[3:0], od[k]);
            check("step_fdly", fdly_o[3:0], of[k]);
            k++;
         end
      end
      wait_idle();

      send(3'd0, 4'h1, 4'h5, 4'h1, 1, 0, 13, 8'h01, 8'h85, 8'h01);
      wait_idle();

      // Downward wrap 1 -> 0,15,14, then the 8-step tie resolved upward.
      seen.delete();
      send(3'd0, 4'hE, 4'h7, 4'h3, 1, 0, 18, 8'h0E, 8'h87, 8'h03);
      wait_idle();
      check("wrap_dn_len", seen.size(), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < seen.size()) check("wrap_dn_seq", seen[i], wrap_a[i]);
      seen.delete();
      send(3'd0, 4'h6, 4'h9, 4'h4, 1, 0, 43, 8'h06, 8'h89, 8'h04);
      wait_idle();
      check("tie_up_len", seen.size(), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < seen.size()) check("tie_up_seq", seen[i], wrap_b[i]);

      // Lock filter on ch1, then a one-cycle glitch restarting the count.
      @(negedge clkin);
      pll_lock[1] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         @(negedge clkin);
         if (t == 9)  check("filt_early", locked_o[1], 1'b0);
         if (t == 10) check("filt_rise",  locked_o[1], 1'b1);
      end
      pll_lock[1] = 1'b0;
      @(negedge clkin);
      pll_lock[1] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         @(negedge clkin);
         if (t == 1)  check("glitch_fall",  locked_o[1], 1'b0);
         if (t == 9)  check("glitch_early", locked_o[1], 1'b0);
         if (t == 10) check("glitch_rise",  locked_o[1], 1'b1);
      end

      // ch1: one down-step 0 -> 15, then a zero-step request.
      send(3'd1, 4'hF, 4'h2, 4'h7, 1, 0, 8, 8'hF6, 8'h29, 8'h74);
      wait_idle();
      send(3'd1, 4'hF, 4'h4, 4'h5, 1, 0, 3, 8'hF6, 8'h49, 8'h54);
      wait_idle();

      // Lock loss in the second SETTLE of a 3-step walk: abort with psda left at 8.
      send(3'd0, 4'h9, 4'hA, 4'hB, 1, 1, 11, 8'hF8, 8'h49, 8'h54);
      repeat (7) @(negedge clkin);
      pll_lock[0] = 1'b0;
      wait_idle();
      pll_lock[0] = 1'b1;
      repeat (12) @(negedge clkin);
      check("relock_ch0", locked_o, 2'b11);

      // Reset mid-SETTLE: outputs return to reset values at once and no pulse follows.
      send(3'd1, 4'h3, 4'h1, 4'h1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      repeat (4) @(negedge clkin);
      check("pre_rst_busy", busy, 1'b1);
      resetn = 1'b0;
      #1;
      check("mid_rst_psda", psda_o, 8'h00);
      check("mid_rst_duty", dutyda_o, 8'h88);
      check("mid_rst_fdly", fdly_o, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      @(negedge clkin);
      resetn = 1'b1;
      #1;
      check("post_rst_ready", req_ready, 1'b1);
      repeat (30) @(negedge clkin);
      check("sb_final", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
